// File: rtl/vc_pop_arbiter.sv
// Two-VC pop arbiter feeding the VC output mux: VC0 priority with a bounded
// burst so VC1 cannot starve, global stall on any downstream almost-full.
module vc_pop_arbiter #(
  parameter int VC0_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic       d0_almost_full,
  input  logic       d1_almost_full,
  output logic       pop_vc0,
  output logic       pop_vc1,
  output logic       pop_delay_vc0,
  output logic       pop_delay_vc1,
  output logic       valid_out,
  output logic [1:0] arb_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_VC0 = 2'd1,
    SERVE_VC1 = 2'd2,
    STALL     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(VC0_BURST);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_next;
  logic             r_pop_delay_vc0;
  logic             r_pop_delay_vc1;
  logic             r_valid_out;
  logic             w_stall;
  logic             w_pop_vc0;
  logic             w_pop_vc1;

  assign w_stall = d0_almost_full | d1_almost_full;

  always_comb begin
    w_pop_vc0        = 1'b0;
    w_pop_vc1        = 1'b0;
    w_state_next     = IDLE;
    w_burst_cnt_next = r_burst_cnt;
    if (!reset) begin
      if (w_stall) begin
        w_state_next = STALL;
      end else if (!vc0_empty && (vc1_empty || (r_burst_cnt < BURST_MAX))) begin
        w_pop_vc0    = 1'b1;
        w_state_next = SERVE_VC0;
      end else if (!vc1_empty) begin
        w_pop_vc1    = 1'b1;
        w_state_next = SERVE_VC1;
      end
      // The burst only counts VC0 pops made while VC1 is actually waiting.
      if (vc1_empty || w_pop_vc1) begin
        w_burst_cnt_next = '0;
      end else if (w_pop_vc0 && (r_burst_cnt < BURST_MAX)) begin
        w_burst_cnt_next = r_burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_burst_cnt     <= '0;
      r_pop_delay_vc0 <= 1'b0;
      r_pop_delay_vc1 <= 1'b0;
      r_valid_out     <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_burst_cnt     <= w_burst_cnt_next;
      r_pop_delay_vc0 <= w_pop_vc0;
      r_pop_delay_vc1 <= w_pop_vc1;
      r_valid_out     <= r_pop_delay_vc0 | r_pop_delay_vc1;
    end
  end

  assign pop_vc0       = w_pop_vc0;
  assign pop_vc1       = w_pop_vc1;
  assign pop_delay_vc0 = r_pop_delay_vc0;
  assign pop_delay_vc1 = r_pop_delay_vc1;
  assign valid_out     = r_valid_out;
  assign arb_state     = r_state;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Scoreboard bench for vc_pop_arbiter: a grant-history reference model pushes
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_vc_pop_arbiter;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vc0_empty = 1'b1;
  logic       vc1_empty = 1'b1;
  logic       d0_almost_full = 1'b0;
  logic       d1_almost_full = 1'b0;
  logic       pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, valid_out;
  logic [1:0] arb_state;

  vc_pop_arbiter #(.VC0_BURST(BURST), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .pop_delay_vc0  (pop_delay_vc0),
    .pop_delay_vc1  (pop_delay_vc1),
    .valid_out      (valid_out),
    .arb_state      (arb_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       p0, p1, d0, d1, v;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference model: grant history (0 none, 1 VC0, 2 VC1) and a plain burst count.
  int m_cnt = 0;
  int m_state = 0;
  int m_g1 = 0;  // grant one cycle ago
  int m_g2 = 0;  // grant two cycles ago
  int m_grant = 0;

  task automatic chk(input string name, input int c, input int got, input int exp_v);
    n_checks++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, exp_v);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pop_vc0", e.cyc, int'(pop_vc0), int'(e.p0));
        chk("pop_vc1", e.cyc, int'(pop_vc1), int'(e.p1));
        chk("pop_delay_vc0", e.cyc, int'(pop_delay_vc0), int'(e.d0));
        chk("pop_delay_vc1", e.cyc, int'(pop_delay_vc1), int'(e.d1));
        chk("valid_out", e.cyc, int'(valid_out), int'(e.v));
        chk("arb_state", e.cyc, int'(arb_state), int'(e.st));
        $display("cyc=%0d pop=%0b%0b dly=%0b%0b v=%0b st=%0d", e.cyc,
                 pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, valid_out, arb_state);
      end
    end
  end

  task automatic step(input logic rst, input logic e0, input logic e1,
                      input logic a0, input logic a1);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; vc0_empty = e0; vc1_empty = e1;
    d0_almost_full = a0; d1_almost_full = a1;
    cyc++;
    if (rst) m_grant = 0;
    else if (a0 || a1) m_grant = 0;
    else if (!e0 && (e1 || m_cnt < BURST)) m_grant = 1;
    else if (!e1) m_grant = 2;
    else m_grant = 0;
    e.cyc = cyc;
    e.p0 = (m_grant == 1);
    e.p1 = (m_grant == 2);
    e.d0 = (m_g1 == 1);
    e.d1 = (m_g1 == 2);
    e.v  = (m_g2 != 0);
    e.st = 2'(m_state);
    sb.push_back(e);
    if (rst) begin
      m_cnt = 0; m_state = 0; m_g1 = 0; m_g2 = 0;
    end else begin
      if (e1 || m_grant == 2) m_cnt = 0;
      else if (m_grant == 1 && m_cnt < BURST) m_cnt++;
      m_state = (a0 || a1) ? 3 : m_grant;
      m_g2 = m_g1;
      m_g1 = m_grant;
    end
  endtask

  initial begin
    int words;
    int guard;
    // Bring registers to a known state before any expectations exist.
    repeat (2) @(posedge clk);
    // Reset held with both VCs non-empty: no pops, all registered outputs zero.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // VC0 holds three words, VC1 empty.
    words = 3;
    for (int i = 0; i < 7; i++) begin
      step(0, words == 0, 1, 0, 0);
      if (m_grant == 1) words--;
    end
    // Both VCs permanently non-empty: 0,0,0,0,1 pattern.
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0);
    // Three-cycle stall mid-stream, then resume.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    // Reset one cycle after a VC1 pop.
    guard = 0;
    do begin
      step(0, 0, 0, 0, 0);
      guard++;
    end while (m_grant != 2 && guard < 10);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // VC1 drains after two VC0 pops; its next arrival waits a full burst.
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    // Randomized traffic with occasional stalls and rare resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
